// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Width of a counter that walks the bit positions 0..width-1.
  function automatic int cntWidth(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_addsub_full_adder.sv
// One-bit full adder made of two half-adder stages whose carries are ORed.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic halfSum;
  logic halfCarry;
  logic secondCarry;

  // First half-adder stage combines the two operand bits.
  assign halfSum   = a ^ b;
  assign halfCarry = a & b;

  // Second half-adder stage folds in the incoming carry; either stage may carry out.
  assign sum         = halfSum ^ cin;
  assign secondCarry = halfSum & cin;
  assign cout        = halfCarry | secondCarry;

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell processes one bit per clock,
// LSB first, between a valid/ready operand handshake and a valid/ready result
// handshake. Defining SERIAL_ADDSUB_FLAGS_EN adds registered zero/negative flags.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
`ifdef SERIAL_ADDSUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             negative
`endif
);

  localparam int CNT_W = cntWidth(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MSB_CIN_STEP = CNT_W'(WIDTH - 2);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  aSr_q, aSr_d;
  logic [WIDTH-1:0]  bSr_q, bSr_d;
  logic [WIDTH-1:0]  resSr_q, resSr_d;
  logic              carry_q, carry_d;
  logic              modeSub_q, modeSub_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cInMsb_q, cInMsb_d;
  logic              carryOut_q, carryOut_d;
  logic              overflow_q, overflow_d;
`ifdef SERIAL_ADDSUB_FLAGS_EN
  logic              orAcc_q, orAcc_d;
  logic              zero_q, zero_d;
  logic              negative_q, negative_d;
`endif

  logic faSum;
  logic faCout;

  full_adder_cell u_fa (
    .a    (aSr_q[0]),
    .b    (bSr_q[0]),
    .cin  (carry_q),
    .sum  (faSum),
    .cout (faCout)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = resSr_q;
  assign carry     = carryOut_q;
  assign overflow  = overflow_q;
`ifdef SERIAL_ADDSUB_FLAGS_EN
  assign zero      = zero_q;
  assign negative  = negative_q;
`endif

  // Next-state logic: subtraction is A + ~B + 1, so the carry register is preset
  // to 1 and B is stored inverted; the final step turns the carry into a borrow.
  always_comb begin
    state_d    = state_q;
    aSr_d      = aSr_q;
    bSr_d      = bSr_q;
    resSr_d    = resSr_q;
    carry_d    = carry_q;
    modeSub_d  = modeSub_q;
    cnt_d      = cnt_q;
    cInMsb_d   = cInMsb_q;
    carryOut_d = carryOut_q;
    overflow_d = overflow_q;
`ifdef SERIAL_ADDSUB_FLAGS_EN
    orAcc_d    = orAcc_q;
    zero_d     = zero_q;
    negative_d = negative_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          aSr_d     = a;
          bSr_d     = (mode == MODE_SUB) ? ~b : b;
          carry_d   = (mode == MODE_SUB);
          modeSub_d = (mode == MODE_SUB);
          cnt_d     = '0;
          state_d   = RUN;
`ifdef SERIAL_ADDSUB_FLAGS_EN
          orAcc_d   = 1'b0;
`endif
        end
      end
      RUN: begin
        resSr_d = {faSum, resSr_q[WIDTH-1:1]};
        aSr_d   = {1'b0, aSr_q[WIDTH-1:1]};
        bSr_d   = {1'b0, bSr_q[WIDTH-1:1]};
        carry_d = faCout;
        cnt_d   = cnt_q + CNT_W'(1);
`ifdef SERIAL_ADDSUB_FLAGS_EN
        orAcc_d = orAcc_q | faSum;
`endif
        if (cnt_q == MSB_CIN_STEP) begin
          cInMsb_d = faCout;
        end
        if (cnt_q == LAST_STEP) begin
          carryOut_d = modeSub_q ? ~faCout : faCout;
          overflow_d = faCout ^ cInMsb_q;
          cnt_d      = '0;
          state_d    = DONE;
`ifdef SERIAL_ADDSUB_FLAGS_EN
          zero_d     = ~(orAcc_q | faSum);
          negative_d = faSum;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      aSr_q      <= '0;
      bSr_q      <= '0;
      resSr_q    <= '0;
      carry_q    <= 1'b0;
      modeSub_q  <= 1'b0;
      cnt_q      <= '0;
      cInMsb_q   <= 1'b0;
      carryOut_q <= 1'b0;
      overflow_q <= 1'b0;
`ifdef SERIAL_ADDSUB_FLAGS_EN
      orAcc_q    <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      aSr_q      <= aSr_d;
      bSr_q      <= bSr_d;
      resSr_q    <= resSr_d;
      carry_q    <= carry_d;
      modeSub_q  <= modeSub_d;
      cnt_q      <= cnt_d;
      cInMsb_q   <= cInMsb_d;
      carryOut_q <= carryOut_d;
      overflow_q <= overflow_d;
`ifdef SERIAL_ADDSUB_FLAGS_EN
      orAcc_q    <= orAcc_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed testbench for serial_addsub at WIDTH=8. Flag checks are included
// when SERIAL_ADDSUB_FLAGS_EN is defined.
module tb_serial_addsub;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry;
  logic       overflow;
`ifdef SERIAL_ADDSUB_FLAGS_EN
  logic       zero;
  logic       negative;
`endif

  int vectorCount = 0;
  int missCount   = 0;

  logic [7:0] opResult;
  logic       opCarry;
  logic       opOverflow;
  logic       opZero;
  logic       opNegative;
  int         opLatency;

  serial_addsub #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow)
`ifdef SERIAL_ADDSUB_FLAGS_EN
    ,
    .zero      (zero),
    .negative  (negative)
`endif
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation end to end, reporting the DONE outputs and the number of
  // edges from acceptance to out_valid (-1 if the handshake never completed).
  task automatic runOp(input logic [7:0] av, input logic [7:0] bv, input logic m);
    int guard;
    opLatency = -1;
    guard = 0;
    while (!in_ready && guard < 40) begin
      tick();
      guard++;
    end
    a        = av;
    b        = bv;
    mode     = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = 8'hA5;
    b        = 8'h5A;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (out_valid) begin
        opLatency = i;
        break;
      end
    end
    opResult   = result;
    opCarry    = carry;
    opOverflow = overflow;
`ifdef SERIAL_ADDSUB_FLAGS_EN
    opZero     = zero;
    opNegative = negative;
`else
    opZero     = 1'b0;
    opNegative = 1'b0;
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectorCount++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    vectorCount++;
    if (result !== 8'h00 || carry !== 1'b0 || overflow !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL reset_outputs: result=%h carry=%b ovf=%b, required 00/0/0", result, carry, overflow);
    end
  endtask

  task automatic test_add();
    logic [7:0] va [3] = '{8'h0F, 8'hFF, 8'h7F};
    logic [7:0] vb [3] = '{8'h01, 8'h01, 8'h01};
    logic [7:0] vr [3] = '{8'h10, 8'h00, 8'h80};
    logic       vc [3] = '{1'b0, 1'b1, 1'b0};
    logic       vo [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      runOp(va[i], vb[i], 1'b0);
      vectorCount++;
      if (opLatency !== 8) begin
        missCount++;
        $display("[TB] FAIL add_latency %h+%h: got %0d edges, required 8", va[i], vb[i], opLatency);
      end
      vectorCount++;
      if (opResult !== vr[i] || opCarry !== vc[i] || opOverflow !== vo[i]) begin
        missCount++;
        $display("[TB] FAIL add %h+%h: result=%h carry=%b ovf=%b, required %h/%b/%b",
                 va[i], vb[i], opResult, opCarry, opOverflow, vr[i], vc[i], vo[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [7:0] va [4] = '{8'h05, 8'h80, 8'h5A, 8'h22};
    logic [7:0] vb [4] = '{8'h07, 8'h01, 8'h00, 8'h22};
    logic [7:0] vr [4] = '{8'hFE, 8'h7F, 8'h5A, 8'h00};
    logic       vc [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic       vo [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      runOp(va[i], vb[i], 1'b1);
      vectorCount++;
      if (opLatency !== 8 || opResult !== vr[i] || opCarry !== vc[i] || opOverflow !== vo[i]) begin
        missCount++;
        $display("[TB] FAIL sub %h-%h: lat=%0d result=%h borrow=%b ovf=%b, required 8/%h/%b/%b",
                 va[i], vb[i], opLatency, opResult, opCarry, opOverflow, vr[i], vc[i], vo[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    a        = 8'h10;
    b        = 8'h20;
    mode     = 1'b0;
    in_valid = 1'b1;
    tick();
    a = 8'hAA;
    b = 8'h55;
    mode = 1'b1;
    guard = 0;
    while (!out_valid && guard < 40) begin
      tick();
      guard++;
    end
    vectorCount++;
    if (out_valid !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL bp_done: out_valid=%b, required 1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectorCount++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'h30 || carry !== 1'b0) begin
        missCount++;
        $display("[TB] FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b result=%h carry=%b, required 1/0/30/0",
                 i, out_valid, in_ready, result, carry);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectorCount++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL bp_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    tick();
    vectorCount++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL bp_single_transfer: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    logic sawValid;
    a        = 8'h11;
    b        = 8'h22;
    mode     = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    vectorCount++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 8'h00 || carry !== 1'b0 || overflow !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL mid_run_reset: in_ready=%b out_valid=%b result=%h carry=%b ovf=%b, required 1/0/00/0/0",
               in_ready, out_valid, result, carry, overflow);
    end
    sawValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) sawValid = 1'b1;
    end
    vectorCount++;
    if (sawValid !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL mid_run_no_partial: out_valid seen=%b, required 0", sawValid);
    end
    runOp(8'h03, 8'h04, 1'b0);
    vectorCount++;
    if (opLatency !== 8 || opResult !== 8'h07 || opCarry !== 1'b0 || opOverflow !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL post_reset_add: lat=%0d result=%h carry=%b ovf=%b, required 8/07/0/0",
               opLatency, opResult, opCarry, opOverflow);
    end
  endtask

`ifdef SERIAL_ADDSUB_FLAGS_EN
  task automatic test_flags();
    runOp(8'h22, 8'h22, 1'b1);
    vectorCount++;
    if (opResult !== 8'h00 || opZero !== 1'b1 || opNegative !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL flags_sub_equal: result=%h zero=%b neg=%b, required 00/1/0", opResult, opZero, opNegative);
    end
    runOp(8'h40, 8'h40, 1'b0);
    vectorCount++;
    if (opResult !== 8'h80 || opZero !== 1'b0 || opNegative !== 1'b1 || opOverflow !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL flags_add_neg: result=%h zero=%b neg=%b ovf=%b, required 80/0/1/1",
               opResult, opZero, opNegative, opOverflow);
    end
  endtask
`endif

  // Runs each scenario in order and prints the summary.
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    mode      = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
`ifdef SERIAL_ADDSUB_FLAGS_EN
    test_flags();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
